// File: rtl/mant_mul_seq.sv
// Iterative radix-2 shift-and-add multiplier for 24-bit mantissas (48-bit raw product).
// One multiplier bit is retired per clock through a single 48-bit adder; latency is fixed at 24 cycles.

module add_48bits (
    input  logic [47:0] i_a,
    input  logic [47:0] i_b,
    input  logic        i_carry,
    output logic [47:0] o_sum,
    output logic        o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {48'b0, i_carry};

endmodule

module mant_mul_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [23:0] i_mcand,
    input  logic [23:0] i_mplier,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [47:0] o_product,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [47:0] acc;
    logic [47:0] mcand_sh;
    logic [23:0] mplier_sh;
    logic [4:0]  cnt;
    logic [47:0] addend;
    logic [47:0] sum;
    logic        add_carry_unused;
    logic        last_bit;

    // The product always fits in 48 bits, so the adder carry-out is never consumed.
    assign addend   = mplier_sh[0] ? mcand_sh : 48'b0;
    assign last_bit = (cnt == 5'd23);

    add_48bits u_add (
        .i_a     (acc),
        .i_b     (addend),
        .i_carry (1'b0),
        .o_sum   (sum),
        .o_carry (add_carry_unused)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid)  state_next = BUSY;
            BUSY:    if (last_bit) state_next = DONE;
            DONE:    if (i_ready)  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_busy  = (state == BUSY);
        o_valid = (state == DONE);
    end

    // Operands are captured only at the accept edge, so later input changes cannot disturb the result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= 48'b0;
            mcand_sh  <= 48'b0;
            mplier_sh <= 24'b0;
            cnt       <= 5'd0;
            o_product <= 48'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand_sh  <= {24'b0, i_mcand};
                        mplier_sh <= i_mplier;
                        acc       <= 48'b0;
                        cnt       <= 5'd0;
                    end
                end
                BUSY: begin
                    acc       <= sum;
                    mcand_sh  <= {mcand_sh[46:0], 1'b0};
                    mplier_sh <= {1'b0, mplier_sh[23:1]};
                    cnt       <= cnt + 5'd1;
                    if (last_bit) begin
                        o_product <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed testbench for mant_mul_seq: latency, products, handshake hold, operand isolation and mid-op reset.

module tb_mant_mul_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_mcand;
    logic [23:0] i_mplier;
    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_product;
    logic        o_busy;

    int checks;
    int errors;

    mant_mul_seq dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_mcand   (i_mcand),
        .i_mplier  (i_mplier),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_product (o_product),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Presents an operand pair for exactly one edge; returns #1 after the accept edge.
    task automatic accept(input logic [23:0] a, input logic [23:0] b);
        i_mcand  = a;
        i_mplier = b;
        i_valid  = 1'b1;
        step();
        i_valid  = 1'b0;
    endtask

    // Counts edges from the accept edge until o_valid, tallying any adder carry seen while busy.
    task automatic wait_done(input int start, output int lat, output int carry_hits);
        lat        = start;
        carry_hits = 0;
        while (lat < 40) begin
            if (o_busy && dut.u_add.o_carry) carry_hits++;
            if (o_valid) break;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: ready/valid/busy=%b%b%b expected 100", o_ready, o_valid, o_busy);
        end
        checks++;
        if (o_product !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_product: got %h expected 0", o_product);
        end
    endtask

    task automatic test_msb();
        int lat, ch;
        i_ready = 1'b1;
        accept(24'h800000, 24'h800000);
        wait_done(0, lat, ch);
        checks++;
        if (lat !== 24) begin
            errors++;
            $display("[TB] FAIL msb_latency: got %0d expected 24", lat);
        end
        checks++;
        if (o_product !== 48'h400000000000 || o_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL msb_product: got %h ready=%b expected 400000000000 ready=0", o_product, o_ready);
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_product !== 48'h400000000000) begin
            errors++;
            $display("[TB] FAIL msb_to_idle: valid=%b ready=%b prod=%h expected 0 1 400000000000", o_valid, o_ready, o_product);
        end
    endtask

    task automatic test_all_ones();
        int lat, ch;
        accept(24'hFFFFFF, 24'hFFFFFF);
        wait_done(0, lat, ch);
        checks++;
        if (o_product !== 48'hFFFFFE000001 || lat !== 24) begin
            errors++;
            $display("[TB] FAIL ones_product: got %h lat %0d expected FFFFFE000001 lat 24", o_product, lat);
        end
        checks++;
        if (ch !== 0) begin
            errors++;
            $display("[TB] FAIL ones_carry: got %0d carry cycles expected 0", ch);
        end
        step();
    endtask

    task automatic test_operand_change();
        int lat, ch;
        accept(24'hC00000, 24'hA00000);
        step();
        i_mcand  = 24'h123456;
        i_mplier = 24'h654321;
        step();
        i_mcand  = 24'hFFFFFF;
        i_mplier = 24'h000001;
        wait_done(2, lat, ch);
        checks++;
        if (o_product !== 48'h780000000000 || lat !== 24) begin
            errors++;
            $display("[TB] FAIL opchange_product: got %h lat %0d expected 780000000000 lat 24", o_product, lat);
        end
        step();
    endtask

    task automatic test_zero_and_ignore();
        int lat, ch;
        accept(24'h000000, 24'hFFFFFF);
        i_mcand  = 24'hFFFFFF;
        i_mplier = 24'hFFFFFF;
        i_valid  = 1'b1;
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_ready: ready=%b busy=%b expected 0 1", o_ready, o_busy);
        end
        step();
        step();
        step();
        i_valid = 1'b0;
        wait_done(3, lat, ch);
        checks++;
        if (o_product !== 48'h0 || lat !== 24) begin
            errors++;
            $display("[TB] FAIL zero_product: got %h lat %0d expected 0 lat 24", o_product, lat);
        end
        step();
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_idle: ready=%b busy=%b expected 1 0", o_ready, o_busy);
        end
    endtask

    task automatic test_hold();
        int lat, ch, bad;
        i_ready = 1'b0;
        accept(24'h400000, 24'h400000);
        wait_done(0, lat, ch);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_product !== 48'h100000000000) bad++;
            step();
        end
        checks++;
        if (bad !== 0 || lat !== 24) begin
            errors++;
            $display("[TB] FAIL hold_stable: %0d unstable cycles lat %0d prod %h expected 0 lat 24 prod 100000000000", bad, lat, o_product);
        end
        i_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_product !== 48'h100000000000) begin
            errors++;
            $display("[TB] FAIL hold_release: valid=%b ready=%b prod=%h expected 0 1 100000000000", o_valid, o_ready, o_product);
        end
        accept(24'h000003, 24'h000005);
        wait_done(0, lat, ch);
        checks++;
        if (o_product !== 48'h00000000000F || lat !== 24) begin
            errors++;
            $display("[TB] FAIL back_to_back: got %h lat %0d expected F lat 24", o_product, lat);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat, ch;
        accept(24'hFFFFFF, 24'hFFFFFF);
        for (int k = 0; k < 11; k++) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_product !== 48'h0) begin
            errors++;
            $display("[TB] FAIL midreset_state: ready=%b valid=%b busy=%b prod=%h expected 1 0 0 0", o_ready, o_valid, o_busy, o_product);
        end
        accept(24'h123456, 24'h000002);
        wait_done(0, lat, ch);
        checks++;
        if (o_product !== 48'h0000002468AC || lat !== 24) begin
            errors++;
            $display("[TB] FAIL midreset_newop: got %h lat %0d expected 0000002468AC lat 24", o_product, lat);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_mcand  = 24'h0;
        i_mplier = 24'h0;
        test_reset();
        test_msb();
        test_all_ones();
        test_operand_change();
        test_zero_and_ignore();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
